// File: rtl/irq_pkg.sv
// Shared constants and decode helpers for the interrupt pending latch.
package irq_pkg;

  localparam int WIDTH = 8;
  localparam int IDW   = 3;

  function automatic logic [WIDTH-1:0] onehot(
    input logic [IDW-1:0] id
  );
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++)
      m[i] = (id == IDW'(i));
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] above_mask(
    input logic [IDW-1:0] idx
  );
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++)
      m[i] = (IDW'(i) > idx);
    return m;
  endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Request, acknowledge and pending-status bundle of the pending latch.
interface irq_pending_latch_if;
  import irq_pkg::*;

  logic [WIDTH-1:0] irq_in;
  logic [WIDTH-1:0] mask;
  logic             ack;
  logic [IDW-1:0]   ack_id;
  logic             eoi;
  logic [IDW-1:0]   eoi_id;
  logic [WIDTH-1:0] pending;
  logic             irq_valid;
  logic [WIDTH-1:0] isr;
  logic             ack_err;

  modport master (
    output irq_in, mask, ack, ack_id,
    output eoi, eoi_id,
    input  pending, irq_valid, isr, ack_err
  );

  modport slave (
    input  irq_in, mask, ack, ack_id,
    input  eoi, eoi_id,
    output pending, irq_valid, isr, ack_err
  );

endinterface

// File: rtl/priority_encoder.sv
// Index of the highest set bit; bit WIDTH-1 wins, zero input gives 0.
module priority_encoder
  import irq_pkg::*;
(
  input  logic [WIDTH-1:0] d,
  output logic [IDW-1:0]   y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < WIDTH; i++)
      if (d[i]) y = IDW'(i);
  end

endmodule

// File: rtl/irq_pending_latch.sv
// Rising-edge interrupt capture with mask, ack/eoi and nesting gate.
module irq_pending_latch
  import irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  irq_pending_latch_if.slave bus
);

  logic [WIDTH-1:0] irq_q;
  logic [WIDTH-1:0] raw_pend;
  logic [WIDTH-1:0] isr_q;
  logic             ack_err_q;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] prio_gate;
  logic [WIDTH-1:0] pend_c;
  logic [WIDTH-1:0] ack_oh;
  logic [WIDTH-1:0] ack_acc;
  logic [WIDTH-1:0] eoi_oh;
  logic [IDW-1:0]   isr_top;
  logic             ack_ok;

  priority_encoder u_isr_enc (
    .d (isr_q),
    .y (isr_top)
  );

  assign rise      = bus.irq_in & ~irq_q;
  assign prio_gate = (isr_q == '0) ? '1
                   : above_mask(isr_top);
  assign pend_c    = raw_pend & ~bus.mask
                   & prio_gate;

  // out-of-range ids decode to zero: ack rejects, eoi ignored
  assign ack_oh  = onehot(bus.ack_id);
  assign ack_ok  = bus.ack & |(ack_oh & pend_c);
  assign ack_acc = ack_ok ? ack_oh : '0;
  assign eoi_oh  = bus.eoi ? onehot(bus.eoi_id)
                 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      raw_pend  <= '0;
      isr_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      irq_q     <= bus.irq_in;
      raw_pend  <= (raw_pend & ~ack_acc) | rise;
      isr_q     <= (isr_q & ~eoi_oh) | ack_acc;
      ack_err_q <= bus.ack & ~ack_ok;
    end
  end

  assign bus.pending   = pend_c;
  assign bus.irq_valid = |pend_c;
  assign bus.isr       = isr_q;
  assign bus.ack_err   = ack_err_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed self-checking bench for irq_pending_latch.
module tb_irq_pending_latch;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  irq_pending_latch_if bus ();

  irq_pending_latch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_ack(input logic [IDW-1:0] id);
    bus.ack = 1'b1; bus.ack_id = id;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic do_eoi(input logic [IDW-1:0] id);
    bus.eoi = 1'b1; bus.eoi_id = id;
    step();
    bus.eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_in = 8'hFF; bus.mask = 8'h00;
    bus.ack = 1'b0; bus.ack_id = '0;
    bus.eoi = 1'b0; bus.eoi_id = '0;
    step();
    chk("rst_pend", 32'(bus.pending), 32'h00);
    step();
    chk("rst_pend2", 32'(bus.pending), 32'h00);
    chk("rst_valid", 32'(bus.irq_valid), 32'h0);
    chk("rst_isr", 32'(bus.isr), 32'h00);
    chk("rst_err", 32'(bus.ack_err), 32'h0);
    rst = 1'b0;
    step();
    chk("rel_pend", 32'(bus.pending), 32'hFF);
    chk("rel_valid", 32'(bus.irq_valid), 32'h1);
    step();
    chk("rel_hold", 32'(bus.pending), 32'hFF);
    rst = 1'b1; bus.irq_in = 8'h00;
    step();
    rst = 1'b0;
    chk("clr_pend", 32'(bus.pending), 32'h00);

    bus.irq_in = 8'h04;
    step();
    chk("cap2", 32'(bus.pending), 32'h04);
    do_ack(3'd2);
    chk("ack2_pend", 32'(bus.pending), 32'h00);
    chk("ack2_isr", 32'(bus.isr), 32'h04);
    do_eoi(3'd2);
    chk("eoi2_isr", 32'(bus.isr), 32'h00);
    chk("eoi2_pend", 32'(bus.pending), 32'h00);
    bus.irq_in = 8'h00;
    step();

    bus.irq_in = 8'h42;
    step();
    chk("nest_cap", 32'(bus.pending), 32'h42);
    do_ack(3'd6);
    chk("nest_isr6", 32'(bus.isr), 32'h40);
    chk("nest_gate", 32'(bus.pending), 32'h00);
    bus.irq_in = 8'hC2;
    step();
    chk("nest_cap7", 32'(bus.pending), 32'h80);
    do_ack(3'd7);
    chk("nest_isr7", 32'(bus.isr), 32'hC0);
    chk("nest_p7", 32'(bus.pending), 32'h00);
    do_eoi(3'd7);
    chk("eoi7_isr", 32'(bus.isr), 32'h40);
    chk("eoi7_pend", 32'(bus.pending), 32'h00);
    do_eoi(3'd6);
    chk("eoi6_isr", 32'(bus.isr), 32'h00);
    chk("eoi6_pend", 32'(bus.pending), 32'h02);
    bus.irq_in = 8'h00;
    do_ack(3'd1);
    chk("ack1_isr", 32'(bus.isr), 32'h02);
    do_eoi(3'd1);
    do_eoi(3'd3);
    chk("eoi_noop", 32'(bus.isr), 32'h00);
    chk("eoi_noerr", 32'(bus.ack_err), 32'h0);

    bus.mask = 8'h10; bus.irq_in = 8'h10;
    step();
    chk("mask_pend", 32'(bus.pending), 32'h00);
    chk("mask_valid", 32'(bus.irq_valid), 32'h0);
    bus.mask = 8'h00;
    #1;
    chk("unmask", 32'(bus.pending), 32'h10);
    chk("unmask_v", 32'(bus.irq_valid), 32'h1);
    do_ack(3'd4);
    do_eoi(3'd4);
    bus.irq_in = 8'h00;
    step();

    bus.irq_in = 8'h01;
    step();
    chk("ill_cap", 32'(bus.pending), 32'h01);
    do_ack(3'd3);
    chk("ill_err", 32'(bus.ack_err), 32'h1);
    chk("ill_pend", 32'(bus.pending), 32'h01);
    chk("ill_isr", 32'(bus.isr), 32'h00);
    step();
    chk("ill_err1", 32'(bus.ack_err), 32'h0);
    do_ack(3'd0);
    chk("ok_isr", 32'(bus.isr), 32'h01);
    chk("ok_err", 32'(bus.ack_err), 32'h0);
    bus.ack = 1'b1; bus.ack_id = 3'd0;
    bus.eoi = 1'b1; bus.eoi_id = 3'd0;
    step();
    bus.ack = 1'b0; bus.eoi = 1'b0;
    chk("ackeoi_err", 32'(bus.ack_err), 32'h1);
    chk("ackeoi_isr", 32'(bus.isr), 32'h00);
    bus.irq_in = 8'h00;
    step();

    bus.irq_in = 8'h20;
    step();
    chk("sim_cap", 32'(bus.pending), 32'h20);
    bus.irq_in = 8'h00;
    step();
    bus.irq_in = 8'h20;
    do_ack(3'd5);
    chk("sim_isr", 32'(bus.isr), 32'h20);
    chk("sim_gate", 32'(bus.pending), 32'h00);
    do_eoi(3'd5);
    chk("sim_repend", 32'(bus.pending), 32'h20);
    bus.irq_in = 8'hA0;
    step();
    chk("sim_cap7", 32'(bus.pending), 32'hA0);
    do_ack(3'd7);
    chk("sim_isr7", 32'(bus.isr), 32'h80);
    chk("sim_p7", 32'(bus.pending), 32'h00);
    rst = 1'b1; bus.irq_in = 8'h00;
    step();
    rst = 1'b0;
    chk("mid_isr", 32'(bus.isr), 32'h00);
    chk("mid_pend", 32'(bus.pending), 32'h00);
    chk("mid_err", 32'(bus.ack_err), 32'h0);
    step();
    chk("mid_pend2", 32'(bus.pending), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
